// File: rtl/rf_pkg.sv
// Shared constants and types for the register file with busy scoreboard.
// Default geometry lives here so the top, read ports and benches agree on it.
package rf_pkg;

  localparam int RF_WIDTH  = 16;
  localparam int RF_DEPTH  = 4;
  localparam int RF_ADDR_W = 3;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]  rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: entry select, zero-register masking, and
// snooping of the write/reservation ports for bypass and busy adjustment.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  entries,
  input  logic [DEPTH-1:0]             busy_vec,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rsv_ok,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic [WIDTH-1:0]             data,
  output logic                         busy
);

  logic wr_match;
  logic rsv_match;

  // wr_valid already excludes out-of-range and zero-register targets.
  assign wr_match  = wr_valid && (addr == wr_addr);
  assign rsv_match = rsv_ok && (addr == rsv_addr);

  always_comb begin
    // NOTE: every output gets a default before any conditional path so no latch is inferred.
    data = '0;
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
        data = entries[i];
        busy = busy_vec[i];
      end
    end
    // A writeback this cycle releases the entry unless it is re-reserved at once.
    if (wr_match) begin
      busy = rsv_match;
      if (BYPASS != 0) begin
        data = wr_data;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// DEPTH x WIDTH register file with one write port, two combinational read
// ports and a per-entry busy scoreboard for in-flight destinations.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              busy_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] entries_q;
  logic [DEPTH-1:0]            busy_q;
  logic [DEPTH-1:0]            busy_d;
  logic [ADDR_W:0]             pend_q;

  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] rsv_dec;
  logic [DEPTH-1:0] wr_clr;
  logic [DEPTH-1:0] rsv_req;
  logic [DEPTH-1:0] rsv_set;
  logic             wr_valid;
  logic             pend_inc;
  logic             pend_dec;

  // One-hot decode of writable entries; out-of-range and zero-register addresses decode to nothing.
  always_comb begin
    wr_dec  = '0;
    rsv_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        wr_dec[i]  = (wr_addr == ADDR_W'(i));
        rsv_dec[i] = (rsv_addr == ADDR_W'(i));
      end
    end
  end

  assign wr_clr   = wr_en  ? wr_dec  : '0;
  assign rsv_req  = rsv_en ? rsv_dec : '0;
  assign wr_valid = |wr_clr;

  // A same-cycle writeback to the requested entry counts as already released.
  assign rsv_ok  = (|rsv_req) && !(|(busy_q & rsv_req & ~wr_clr));
  assign rsv_set = rsv_ok ? rsv_req : '0;
  assign busy_d  = (busy_q & ~wr_clr) | rsv_set;

  assign pend_inc = rsv_ok;
  assign pend_dec = |(busy_q & wr_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the entries are plain flops, so they are reset with everything else and read 0 afterwards.
      entries_q <= '0;
      busy_q    <= '0;
      pend_q    <= '0;
    end else begin
      // NOTE: state is assigned non-blocking so every register samples pre-edge values.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_clr[i]) begin
          entries_q[i] <= wr_data;
        end
      end
      busy_q <= busy_d;
      case ({pend_inc, pend_dec})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  assign pend_cnt = pend_q;

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_a (
    .addr     (rd_addr_a),
    .entries  (entries_q),
    .busy_vec (busy_q),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_ok   (rsv_ok),
    .rsv_addr (rsv_addr),
    .data     (rd_data_a),
    .busy     (busy_a)
  );

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_b (
    .addr     (rd_addr_b),
    .entries  (entries_q),
    .busy_vec (busy_q),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_ok   (rsv_ok),
    .rsv_addr (rsv_addr),
    .data     (rd_data_b),
    .busy     (busy_b)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: three configurations share one stimulus
// stream (default, no bypass, zero register with DEPTH=5).
module tb_regfile_scoreboard;
  import rf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst, wr_en, rsv_en;
  rf_addr_t wr_addr, rd_addr_a, rd_addr_b, rsv_addr;
  rf_data_t wr_data;

  rf_data_t da0, db0, da1, db1, da2, db2;
  logic     ba0, bb0, ok0, ba1, bb1, ok1, ba2, bb2, ok2;
  logic [RF_ADDR_W:0] cnt0, cnt1, cnt2;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] obs[$];
  int          checks   = 0;
  int          failures = 0;

  regfile_scoreboard #(.WIDTH(16), .DEPTH(4), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(da0), .busy_a(ba0),
    .rd_addr_b(rd_addr_b), .rd_data_b(db0), .busy_b(bb0),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok0), .pend_cnt(cnt0)
  );

  regfile_scoreboard #(.WIDTH(16), .DEPTH(4), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(da1), .busy_a(ba1),
    .rd_addr_b(rd_addr_b), .rd_data_b(db1), .busy_b(bb1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok1), .pend_cnt(cnt1)
  );

  regfile_scoreboard #(.WIDTH(16), .DEPTH(5), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(da2), .busy_a(ba2),
    .rd_addr_b(rd_addr_b), .rd_data_b(db2), .busy_b(bb2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok2), .pend_cnt(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string n, input logic [15:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic got(input logic [15:0] v);
    obs.push_back(v);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] o;
    for (int c = 0; c < 6; c++) begin
      wr_en    = 1'b1;
      wr_addr  = rf_addr_t'($urandom_range(0, 7));
      wr_data  = rf_data_t'($urandom);
      rsv_en   = 1'b1;
      rsv_addr = rf_addr_t'($urandom_range(0, 7));
      tick();
    end
    rst      = 1'b1;
    wr_addr  = 3'd1;
    rsv_addr = 3'd1;
    tick();
    rst    = 1'b0;
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_addr_a = rf_addr_t'(i);
      rd_addr_b = rf_addr_t'(4 - i);
      want($sformatf("rst_u0_data_a_%0d", i), 16'h0);
      want($sformatf("rst_u1_data_b_%0d", i), 16'h0);
      want($sformatf("rst_u2_data_a_%0d", i), 16'h0);
      want($sformatf("rst_u0_busy_a_%0d", i), 16'h0);
      want($sformatf("rst_u2_busy_b_%0d", i), 16'h0);
      #2;
      got(da0); got(db1); got(da2); got({15'b0, ba0}); got({15'b0, bb2});
    end
    want("rst_u0_pend", 16'h0);
    want("rst_u1_pend", 16'h0);
    want("rst_u2_pend", 16'h0);
    got({12'b0, cnt0}); got({12'b0, cnt1}); got({12'b0, cnt2});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 16'hxxxx;
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [15:0] o;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
    tick();
    wr_addr = 3'd3; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd3;
    want("wr_u0_a2", 16'h1234); want("wr_u0_b3", 16'hBEEF);
    want("wr_u1_a2", 16'h1234); want("wr_u2_b3", 16'hBEEF);
    #2;
    got(da0); got(db0); got(da1); got(db2);
    rd_addr_a = 3'd5; rd_addr_b = 3'd7;
    want("wr_u0_oor5", 16'h0); want("wr_u2_oor5", 16'h0); want("wr_u0_oor7", 16'h0);
    #2;
    got(da0); got(da2); got(db0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 16'hxxxx;
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [15:0] o;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
    tick();
    wr_data = 16'hA5A5; rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    want("byp_u0_a", 16'hA5A5); want("byp_u1_old", 16'h1111);
    want("byp_u2_a", 16'hA5A5); want("byp_u1_b", 16'hBEEF);
    #2;
    got(da0); got(da1); got(da2); got(db1);
    tick();
    wr_en = 1'b0;
    want("byp_u1_after", 16'hA5A5);
    #2;
    got(da1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 16'hxxxx;
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_reservation();
    exp_t e;
    logic [15:0] o;
    rsv_en = 1'b1; rsv_addr = 3'd2; rd_addr_a = 3'd2;
    want("rsv_u0_ok", 16'h1); want("rsv_u1_ok", 16'h1); want("rsv_u2_ok", 16'h1);
    want("rsv_u0_busy_pre", 16'h0);
    #2;
    got({15'b0, ok0}); got({15'b0, ok1}); got({15'b0, ok2}); got({15'b0, ba0});
    tick();
    want("rsv_again_u0_ok", 16'h0); want("rsv_u0_busy", 16'h1);
    want("rsv_u0_pend", 16'h1); want("rsv_u2_pend", 16'h1);
    #2;
    got({15'b0, ok0}); got({15'b0, ba0}); got({12'b0, cnt0}); got({12'b0, cnt2});
    tick();
    rsv_en = 1'b0;
    want("rsv_rej_u0_pend", 16'h1); want("rsv_rej_u0_busy", 16'h1);
    #2;
    got({12'b0, cnt0}); got({15'b0, ba0});
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
    want("rsv_wb_u0_busy", 16'h0); want("rsv_wb_u0_data", 16'h2222);
    want("rsv_wb_u1_data", 16'h1234); want("rsv_wb_u1_busy", 16'h0);
    #2;
    got({15'b0, ba0}); got(da0); got(da1); got({15'b0, ba1});
    tick();
    wr_en = 1'b0;
    want("rsv_rel_u0_busy", 16'h0); want("rsv_rel_u0_pend", 16'h0);
    want("rsv_rel_u1_pend", 16'h0); want("rsv_rel_u1_data", 16'h2222);
    #2;
    got({15'b0, ba0}); got({12'b0, cnt0}); got({12'b0, cnt1}); got(da1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 16'hxxxx;
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] o;
    rsv_en = 1'b1; rsv_addr = 3'd1; rd_addr_a = 3'd1;
    tick();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0F0F;
    want("b2b_u0_ok", 16'h1); want("b2b_u0_data", 16'h0F0F); want("b2b_u0_busy", 16'h1);
    want("b2b_u0_pend_pre", 16'h1); want("b2b_u1_old", 16'hA5A5); want("b2b_u2_ok", 16'h1);
    #2;
    got({15'b0, ok0}); got(da0); got({15'b0, ba0}); got({12'b0, cnt0}); got(da1); got({15'b0, ok2});
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    want("b2b_post_u0_data", 16'h0F0F); want("b2b_post_u0_busy", 16'h1);
    want("b2b_post_u0_pend", 16'h1); want("b2b_post_u2_pend", 16'h1);
    #2;
    got(da0); got({15'b0, ba0}); got({12'b0, cnt0}); got({12'b0, cnt2});
    wr_en = 1'b1; wr_addr = 3'd1; rsv_en = 1'b1; rsv_addr = 3'd3; rd_addr_b = 3'd3;
    want("swap_u0_ok", 16'h1); want("swap_u0_busy_b_pre", 16'h0);
    #2;
    got({15'b0, ok0}); got({15'b0, bb0});
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    want("swap_u0_busy_a", 16'h0); want("swap_u0_busy_b", 16'h1); want("swap_u0_pend", 16'h1);
    #2;
    got({15'b0, ba0}); got({15'b0, bb0}); got({12'b0, cnt0});
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h3333;
    tick();
    wr_en = 1'b0;
    want("drain_u0_pend", 16'h0); want("drain_u0_busy_b", 16'h0);
    want("drain_u0_data_b", 16'h3333); want("drain_u2_pend", 16'h0);
    #2;
    got({12'b0, cnt0}); got({15'b0, bb0}); got(db0); got({12'b0, cnt2});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 16'hxxxx;
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_zero_reg_range();
    exp_t e;
    logic [15:0] o;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 3'd0; rd_addr_a = 3'd0; rd_addr_b = 3'd4;
    want("zr_u0_ok", 16'h1); want("zr_u0_data", 16'hFFFF); want("zr_u0_busy", 16'h1);
    want("zr_u1_data", 16'h0);
    want("zr_u2_ok", 16'h0); want("zr_u2_data", 16'h0); want("zr_u2_busy", 16'h0);
    want("zr_u2_b4", 16'h0);
    #2;
    got({15'b0, ok0}); got(da0); got({15'b0, ba0}); got(da1);
    got({15'b0, ok2}); got(da2); got({15'b0, ba2}); got(db2);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    want("zr_post_u0_data", 16'hFFFF); want("zr_post_u0_pend", 16'h1);
    want("zr_post_u2_data", 16'h0); want("zr_post_u2_busy", 16'h0); want("zr_post_u2_pend", 16'h0);
    #2;
    got(da0); got({12'b0, cnt0}); got(da2); got({15'b0, ba2}); got({12'b0, cnt2});
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444; rsv_en = 1'b1; rsv_addr = 3'd6;
    want("oor6_u0_ok", 16'h0); want("oor6_u2_ok", 16'h0);
    #2;
    got({15'b0, ok0}); got({15'b0, ok2});
    tick();
    wr_en = 1'b0; rsv_addr = 3'd4;
    want("rsv4_u0_ok", 16'h0); want("rsv4_u2_ok", 16'h1);
    want("rd4_u0_data", 16'h0); want("rd4_u2_data", 16'h4444);
    #2;
    got({15'b0, ok0}); got({15'b0, ok2}); got(db0); got(db2);
    rsv_en = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs.size() > 0) ? obs.pop_front() : 16'hxxxx;
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_reservation();
    test_back_to_back();
    test_zero_reg_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
